// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter with an AXI-lite write-only register interface.
// Sends one byte per TXDATA write as an 11-bit frame: start, 8 data bits LSB first,
// odd parity, stop. It then samples the device ACK and reports the result through
// sticky done/err flags and an irq line.
//
// Ports:
//   clk, rst                  system clock, asynchronous active-high reset
//   aw*/w*/b*                 AXI-lite write channels (awprot, wstrb ignored)
//   irq                       done | err
//   busy                      transfer in progress
//   done, err                 sticky status flags, cleared by W1C writes to STATUS
//   ps2_clk, ps2_data         raw PS/2 line inputs
//   ps2_clk_oe, ps2_data_oe   open-drain pull-low enables
//
// Register map: 0x0 TXDATA (wdata[7:0]), 0x4 STATUS W1C (bit0 done, bit1 err).
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned DEBOUNCE_N     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] awaddr,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        irq,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe
);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StShift,
    StAck,
    StWaitIdle
  } state_e;

  // ---------------------------------------------------------------------------
  // Line debouncers: index 0 is ps2_clk, index 1 is ps2_data. Each output follows
  // its synchronised input once the input has differed for DEBOUNCE_N cycles.
  // ---------------------------------------------------------------------------
  logic [1:0]  raw;
  logic [1:0]  sync1_q, sync2_q, clean_q;
  logic [31:0] db_cnt_q [2];

  assign raw = {ps2_data, ps2_clk};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      clean_q <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == clean_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DEBOUNCE_N - 1) begin
          clean_q[i]  <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 32'd1;
        end
      end
    end
  end

  logic clk_clean, data_clean, clk_prev_q, clk_fall;

  assign clk_clean  = clean_q[0];
  assign data_clean = clean_q[1];
  assign clk_fall   = ~clk_clean & clk_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clk_prev_q <= 1'b1;
    else     clk_prev_q <= clk_clean;
  end

  // ---------------------------------------------------------------------------
  // AXI-lite write capture. AW and W are latched independently; once both are
  // held the write executes for a single cycle, guarded by bvalid.
  // ---------------------------------------------------------------------------
  logic        aw_ok_q, w_ok_q, bvalid_q;
  logic [15:0] addr_q;
  logic [7:0]  wdat_q;
  logic [1:0]  bresp_q;
  logic        exec, wr_tx, wr_st, tx_start;
  state_e      state_q, state_d;

  assign exec     = aw_ok_q & w_ok_q & ~bvalid_q;
  assign wr_tx    = exec && (addr_q == 16'h0000);
  assign wr_st    = exec && (addr_q == 16'h0004);
  assign tx_start = wr_tx && (state_q == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_ok_q  <= 1'b0;
      w_ok_q   <= 1'b0;
      bvalid_q <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
      bresp_q  <= 2'b00;
    end else begin
      if (awvalid && !aw_ok_q) begin
        aw_ok_q <= 1'b1;
        addr_q  <= awaddr;
      end
      if (wvalid && !w_ok_q) begin
        w_ok_q <= 1'b1;
        wdat_q <= wdata[7:0];
      end
      if (exec) begin
        bvalid_q <= 1'b1;
        // A TXDATA write while a frame is in flight is dropped.
        bresp_q  <= (wr_tx && !tx_start) ? 2'b10 : 2'b00;
      end
      if (bvalid_q && bready) begin
        bvalid_q <= 1'b0;
        aw_ok_q  <= 1'b0;
        w_ok_q   <= 1'b0;
      end
    end
  end

  assign awready = ~aw_ok_q;
  assign wready  = ~w_ok_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic        data_oe_q, data_oe_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [10:0] frame;
  logic        set_done, set_err, in_frame, timed_out;
  logic        clk_oe_c, data_oe_c;

  assign frame     = {1'b1, ~^tx_data_q, tx_data_q, 1'b0};
  assign in_frame  = (state_q == StShift) || (state_q == StAck) || (state_q == StWaitIdle);
  assign timed_out = (cnt_q == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_oe_d = data_oe_q;
    tx_data_d = tx_data_q;
    set_done  = 1'b0;
    set_err   = 1'b0;
    clk_oe_c  = 1'b0;
    data_oe_c = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tx_start) begin
          state_d   = StInhibit;
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_data_d = wdat_q;
        end
      end
      StInhibit: begin
        clk_oe_c = 1'b1;
        if (cnt_q == INHIBIT_CYCLES - 1) begin
          state_d = StReq;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StReq: begin
        clk_oe_c  = 1'b1;
        data_oe_c = 1'b1;
        state_d   = StShift;
        bit_idx_d = 4'd1;
        data_oe_d = 1'b1;  // keep the start bit on the line
        cnt_d     = '0;
      end
      StShift: begin
        data_oe_c = data_oe_q;
        if (clk_fall) begin
          data_oe_d = ~frame[bit_idx_q];
          // The edge that puts the stop bit out also arms ACK sampling.
          if (bit_idx_q == 4'd10) state_d = StAck;
          else                    bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      StAck: begin
        if (clk_fall) begin
          if (!data_clean) set_done = 1'b1;
          else             set_err  = 1'b1;
          state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (clk_clean && data_clean) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Device clock watchdog: any falling edge restarts it.
    if (in_frame) begin
      if (clk_fall) begin
        cnt_d = '0;
      end else if (timed_out) begin
        state_d   = StIdle;
        data_oe_d = 1'b0;
        set_err   = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_oe_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_oe_q <= data_oe_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Sticky flags; a set in the same cycle as a W1C clear wins.
  logic done_q, err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= set_done | (done_q & ~(wr_st & wdat_q[0]));
      err_q  <= set_err  | (err_q  & ~(wr_st & wdat_q[1]));
    end
  end

  assign done        = done_q;
  assign err         = err_q;
  assign irq         = done_q | err_q;
  assign busy        = (state_q != StIdle);
  assign ps2_clk_oe  = clk_oe_c;
  assign ps2_data_oe = data_oe_c;

  logic unused_inputs;
  assign unused_inputs = ^{awprot, wstrb, wdata[31:8]};

endmodule

// File: tb/tb_ps2_tx.sv
module tb_ps2_tx;
  localparam int unsigned InhibitCycles = 100;
  localparam int unsigned TimeoutCycles = 2000;
  localparam int unsigned DebounceN     = 4;
  localparam int          Half          = 40;  // device clock half period, in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = 4'hf;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic        irq, busy, done, err;
  logic        clk_oe, data_oe;
  logic        dev_clk_low = 1'b0;
  logic        dev_data_low = 1'b0;
  wire         ps2_clk_line  = ~(clk_oe | dev_clk_low);
  wire         ps2_data_line = ~(data_oe | dev_data_low);

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ps2_tx #(
    .INHIBIT_CYCLES(InhibitCycles),
    .TIMEOUT_CYCLES(TimeoutCycles),
    .DEBOUNCE_N    (DebounceN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .awaddr     (awaddr),
    .awprot     (awprot),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wvalid     (wvalid),
    .wready     (wready),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .irq        (irq),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ps2_clk    (ps2_clk_line),
    .ps2_data   (ps2_data_line),
    .ps2_clk_oe (clk_oe),
    .ps2_data_oe(data_oe)
  );

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // Full AXI write with both channels offered together; resp is X if it never completes.
  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, output logic [1:0] resp);
    logic aw_go, w_go;
    resp = 2'bxx;
    @(negedge clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      aw_go = awvalid & awready;
      w_go  = wvalid & wready;
      @(negedge clk);
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bvalid) begin
        resp = bresp; bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  // PS/2 keyboard model: waits for the host request, clocks 11 pulses, samples the
  // host bits while the clock is low, and optionally pulls data low for the ACK.
  task automatic dev_frame(input bit ack, output logic [7:0] rx, output logic par,
                           output logic stp, output int inh, output bit ok);
    ok = 1'b0; inh = 0; rx = 'x; par = 1'bx; stp = 1'bx;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (ps2_clk_line && !ps2_data_line) begin ok = 1'b1; break; end
      if (!ps2_clk_line && ps2_data_line) inh++;
    end
    if (!ok) return;
    repeat (Half) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      repeat (Half) @(negedge clk);
      if (k <= 8) rx[k-1] = ps2_data_line;
      else if (k == 9) par = ps2_data_line;
      else if (k == 10) begin
        stp = ps2_data_line;
        if (ack) dev_data_low = 1'b1;
      end
      dev_clk_low = 1'b0;
      repeat (Half) @(negedge clk);
    end
    dev_data_low = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({clk_oe, data_oe, busy, done, err, irq, bvalid, bresp} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, want 0", {clk_oe, data_oe, busy, done, err, irq,
               bvalid, bresp});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({awready, wready, busy, clk_oe, data_oe} !== 5'b11000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b, want 11000", {awready, wready, busy, clk_oe,
               data_oe});
    end
  endtask

  task automatic test_led_cmd();
    logic [1:0] r; logic [7:0] rx; logic par, stp; int inh; bit ok;
    fork
      axi_write(16'h0, 32'h0000_00ED, r);
      dev_frame(1'b1, rx, par, stp, inh, ok);
    join
    n_tests++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL led_bresp: got %b, want 00", r); end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL led_complete: got 0, want 1"); end
    n_tests++;
    if (inh != InhibitCycles) begin
      n_fail++; $display("FAIL led_inhibit_len: got %0d, want %0d", inh, InhibitCycles);
    end
    n_tests++;
    if (rx !== 8'hED) begin n_fail++; $display("FAIL led_data: got %h, want ed", rx); end
    n_tests++;
    if ({par, stp} !== 2'b11) begin
      n_fail++; $display("FAIL led_parity_stop: got %b, want 11", {par, stp});
    end
    n_tests++;
    if ({done, err, irq, busy} !== 4'b1010) begin
      n_fail++; $display("FAIL led_flags: got %b, want 1010", {done, err, irq, busy});
    end
  endtask

  task automatic test_parity();
    logic [7:0] bytes [5];
    logic [1:0] r; logic [7:0] rx; logic par, stp; int inh; bit ok;
    bytes[0] = 8'h01; bytes[1] = 8'hFF;
    for (int i = 2; i < 5; i++) bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) begin
      axi_write(16'h4, 32'h1, r);
      n_tests++;
      if (done !== 1'b0) begin
        n_fail++; $display("FAIL par_done_clear[%0d]: got %b, want 0", i, done);
      end
      fork
        axi_write(16'h0, {24'h0, bytes[i]}, r);
        dev_frame(1'b1, rx, par, stp, inh, ok);
      join
      n_tests++;
      if ({ok, rx, par, stp, done} !== {1'b1, bytes[i], odd_parity(bytes[i]), 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL par_frame[%0d]: got ok=%b data=%h par=%b stop=%b done=%b, want data=%h par=%b",
                 i, ok, rx, par, stp, done, bytes[i], odd_parity(bytes[i]));
      end
    end
  endtask

  task automatic test_busy_write();
    logic [1:0] r1, r2; logic [7:0] rx, d; logic par, stp; int inh; bit ok;
    d = 8'($urandom_range(0, 255));
    if (d == 8'hAA) d = 8'h55;
    fork
      axi_write(16'h0, {24'h0, d}, r1);
      dev_frame(1'b1, rx, par, stp, inh, ok);
      begin
        repeat (400) @(negedge clk);
        axi_write(16'h0, 32'h0000_00AA, r2);
      end
    join
    n_tests++;
    if (r2 !== 2'b10) begin n_fail++; $display("FAIL busy_bresp: got %b, want 10", r2); end
    n_tests++;
    if ({ok, rx, par} !== {1'b1, d, odd_parity(d)}) begin
      n_fail++; $display("FAIL busy_frame: got %h, want %h", rx, d);
    end
    repeat (300) @(negedge clk);
    n_tests++;
    if ({busy, clk_oe} !== 2'b00) begin
      n_fail++; $display("FAIL busy_dropped: got %b, want 00", {busy, clk_oe});
    end
  endtask

  task automatic test_timeout();
    logic [1:0] r; int shift_cycles;
    axi_write(16'h4, 32'h3, r);
    n_tests++;
    if ({done, err, irq} !== 3'b000) begin
      n_fail++; $display("FAIL to_clear_all: got %b, want 000", {done, err, irq});
    end
    shift_cycles = 0;
    fork
      axi_write(16'h0, 32'($urandom_range(0, 255)), r);
      begin
        for (int i = 0; i < int'(TimeoutCycles + InhibitCycles) + 300; i++) begin
          @(negedge clk);
          if (ps2_clk_line && !ps2_data_line) shift_cycles++;
          if (shift_cycles > 0 && !busy) break;
        end
      end
    join
    n_tests++;
    if (shift_cycles != TimeoutCycles) begin
      n_fail++; $display("FAIL to_length: got %0d, want %0d", shift_cycles, TimeoutCycles);
    end
    n_tests++;
    if ({busy, clk_oe, data_oe, err, done, irq} !== 6'b000101) begin
      n_fail++; $display("FAIL to_state: got %b, want 000101", {busy, clk_oe, data_oe, err,
               done, irq});
    end
    axi_write(16'h4, 32'h2, r);
    n_tests++;
    if ({r, err, irq} !== 4'b0000) begin
      n_fail++; $display("FAIL to_w1c: got %b, want 0000", {r, err, irq});
    end
  endtask

  task automatic test_no_ack();
    logic [1:0] r; logic [7:0] rx, d; logic par, stp; int inh; bit ok;
    d = 8'($urandom_range(0, 255));
    fork
      axi_write(16'h0, {24'h0, d}, r);
      dev_frame(1'b0, rx, par, stp, inh, ok);
    join
    n_tests++;
    if ({ok, rx, err, done, irq} !== {1'b1, d, 1'b1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL noack_flags: got ok=%b data=%h err=%b done=%b irq=%b, want err=1 done=0",
               ok, rx, err, done, irq);
    end
  endtask

  task automatic test_axi_order_and_reset();
    logic [1:0] r; int held; bit seen;
    @(negedge clk);
    wdata = {24'h0, 8'($urandom_range(0, 255))}; wvalid = 1'b1; awvalid = 1'b0; bready = 1'b0;
    @(negedge clk);
    wvalid = 1'b0;
    n_tests++;
    if ({wready, awready, bvalid} !== 3'b010) begin
      n_fail++; $display("FAIL order_w_only: got %b, want 010", {wready, awready, bvalid});
    end
    repeat (2) @(negedge clk);
    awaddr = 16'h0; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    held = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bvalid) held++;
    end
    n_tests++;
    if (held != 5) begin n_fail++; $display("FAIL order_bvalid_hold: got %0d, want 5", held); end
    r = bresp; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    n_tests++;
    if ({r, bvalid, busy, awready, wready} !== 5'b00111) begin
      n_fail++; $display("FAIL order_handshake: got %b, want 00111", {r, bvalid, busy, awready,
               wready});
    end
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ps2_clk_line && !ps2_data_line) begin seen = 1'b1; break; end
    end
    repeat (20) @(negedge clk);
    n_tests++;
    if ({seen, data_oe} !== 2'b11) begin
      n_fail++; $display("FAIL order_in_shift: got %b, want 11", {seen, data_oe});
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({clk_oe, data_oe, busy, done, err, irq, bvalid} !== 7'b0) begin
      n_fail++; $display("FAIL midframe_reset: got %b, want 0", {clk_oe, data_oe, busy, done,
               err, irq, bvalid});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_led_cmd();
    test_parity();
    test_busy_write();
    test_timeout();
    test_no_ack();
    test_axi_order_and_reset();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
